// File: rtl/defines.sv
// Shared receive-path types: parsed frame header, drain FSM states and the broadcast address.
package defines;

    typedef struct packed {
        logic [47:0] dst_addr;
        logic [47:0] src_addr;
        logic [15:0] length;
    } header;

    typedef enum logic [1:0] {
        IDLE,
        CHECK,
        FORWARD,
        DROP
    } drain_state_e;

    localparam logic [47:0] BCAST_ADDR = 48'hFFFF_FFFF_FFFF;

endpackage

// File: rtl/rx_frame_drain_ctrl.sv
// Drains the rx byte buffer one frame at a time: address filter, then forward or discard; header to first pop 2 cycles, first byte out 3.
// Output register is the only buffering; m_ready low holds m_data/m_last and stalls pops, empty buffer stalls with no timeout.
module rx_frame_drain_ctrl
    import defines::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [47:0]      cfg_mac_addr,
    input  logic             cfg_promisc,
    input  logic             hdr_valid,
    input  header            rx_header,
    input  logic             brx_empty,
    input  logic [7:0]       rx_data,
    output logic             brx_rd_en,
    output logic [7:0]       m_data,
    output logic             m_valid,
    output logic             m_last,
    input  logic             m_ready,
    output logic [47:0]      m_src_addr,
    output logic             busy,
    output logic             hdr_overrun,
    output logic [CNT_W-1:0] frames_fwd,
    output logic [CNT_W-1:0] frames_drop
);

    drain_state_e state_q, state_d;
    logic [47:0]  dst_q;
    logic [15:0]  len_q;
    logic [15:0]  remaining_q;
    logic         accept;
    logic         pop;
    logic         fwd_evt;
    logic         drop_evt;

    assign accept = cfg_promisc || (dst_q == cfg_mac_addr) || (dst_q == BCAST_ADDR);

    always_comb begin
        state_d  = state_q;
        pop      = 1'b0;
        fwd_evt  = 1'b0;
        drop_evt = 1'b0;
        case (state_q)
            IDLE: begin
                if (hdr_valid) state_d = CHECK;
            end
            CHECK: begin
                if (len_q == 16'd0) begin
                    drop_evt = 1'b1;
                    state_d  = IDLE;
                end else if (accept) begin
                    state_d  = FORWARD;
                end else begin
                    drop_evt = 1'b1;
                    state_d  = DROP;
                end
            end
            FORWARD: begin
                // Pop only when the output register is free or draining this cycle.
                pop = !brx_empty && (remaining_q != 16'd0) && (!m_valid || m_ready);
                if (m_valid && m_ready && m_last) begin
                    fwd_evt = 1'b1;
                    state_d = IDLE;
                end
            end
            DROP: begin
                pop = !brx_empty && (remaining_q != 16'd0);
                if (remaining_q == 16'd0) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign brx_rd_en = pop;
    assign busy      = (state_q != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dst_q       <= '0;
            len_q       <= '0;
            remaining_q <= '0;
            m_src_addr  <= '0;
        end else if (state_q == IDLE && hdr_valid) begin
            dst_q       <= rx_header.dst_addr;
            len_q       <= rx_header.length;
            remaining_q <= rx_header.length;
            m_src_addr  <= rx_header.src_addr;
        end else if (pop) begin
            remaining_q <= remaining_q - 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_data  <= '0;
            m_valid <= 1'b0;
            m_last  <= 1'b0;
        end else if (state_q == FORWARD) begin
            if (pop) begin
                m_data  <= rx_data;
                m_valid <= 1'b1;
                m_last  <= (remaining_q == 16'd1);
            end else if (m_valid && m_ready) begin
                m_valid <= 1'b0;
                m_last  <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frames_fwd  <= '0;
            frames_drop <= '0;
            hdr_overrun <= 1'b0;
        end else begin
            if (fwd_evt && (frames_fwd != '1))   frames_fwd  <= frames_fwd + CNT_W'(1);
            if (drop_evt && (frames_drop != '1)) frames_drop <= frames_drop + CNT_W'(1);
            if (hdr_valid && state_q != IDLE)    hdr_overrun <= 1'b1;
        end
    end

endmodule

// File: tb/tb_rx_frame_drain_ctrl.sv
// Directed bench for rx_frame_drain_ctrl: byte-buffer model, expected-stream scoreboard and per-cycle output checks.
module tb_rx_frame_drain_ctrl;
    import defines::*;

    localparam int CNT_W = 16;
    localparam logic [47:0] MAC = 48'hAABB_CCDD_EEFF;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [47:0]      cfg_mac_addr = MAC;
    logic             cfg_promisc = 1'b0;
    logic             hdr_valid = 1'b0;
    header            rx_header = '0;
    logic             brx_empty;
    logic [7:0]       rx_data;
    logic             brx_rd_en;
    logic [7:0]       m_data;
    logic             m_valid;
    logic             m_last;
    logic             m_ready = 1'b1;
    logic [47:0]      m_src_addr;
    logic             busy;
    logic             hdr_overrun;
    logic [CNT_W-1:0] frames_fwd;
    logic [CNT_W-1:0] frames_drop;

    rx_frame_drain_ctrl #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .cfg_mac_addr(cfg_mac_addr), .cfg_promisc(cfg_promisc),
        .hdr_valid(hdr_valid), .rx_header(rx_header), .brx_empty(brx_empty), .rx_data(rx_data),
        .brx_rd_en(brx_rd_en), .m_data(m_data), .m_valid(m_valid), .m_last(m_last),
        .m_ready(m_ready), .m_src_addr(m_src_addr), .busy(busy), .hdr_overrun(hdr_overrun),
        .frames_fwd(frames_fwd), .frames_drop(frames_drop)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Receiver buffer model: first-word fall-through byte queue.
    logic [7:0] mem [0:255];
    logic [7:0] wr_ptr = 8'd0;
    logic [7:0] rd_ptr = 8'd0;
    int         pop_cnt = 0;

    assign brx_empty = (rd_ptr == wr_ptr);
    assign rx_data   = mem[rd_ptr];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= wr_ptr;
        end else if (brx_rd_en) begin
            rd_ptr  <= rd_ptr + 8'd1;
            pop_cnt <= pop_cnt + 1;
        end
    end

    task automatic push_bytes(input logic [7:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            mem[wr_ptr] = base + 8'(i);
            wr_ptr      = wr_ptr + 8'd1;
        end
    endtask

    // Downstream ready: constant 1, or the 1,0,0,1 pattern in back-pressure mode.
    logic       bp_mode = 1'b0;
    int         bp_idx = 0;
    logic [3:0] bp_pat = 4'b1001;
    always @(posedge clk) begin
        #2;
        if (bp_mode) begin
            m_ready = bp_pat[bp_idx % 4];
            bp_idx++;
        end else begin
            m_ready = 1'b1;
        end
    end

    // Frame-level model: what the consumer must see and how counters must move.
    typedef struct {
        logic [7:0]  d;
        logic        l;
        logic [47:0] s;
    } exp_t;
    exp_t exp_q[$];
    int   exp_fwd = 0;
    int   exp_drop = 0;

    task automatic model_frame(input logic [47:0] dst, input logic [47:0] src,
                               input int len, input logic [7:0] base);
        exp_t e;
        logic acc;
        acc = cfg_promisc || (dst == cfg_mac_addr) || (dst == 48'hFFFF_FFFF_FFFF);
        if (len == 0 || !acc) begin
            exp_drop++;
        end else begin
            for (int i = 0; i < len; i++) begin
                e.d = base + 8'(i);
                e.l = (i == len - 1);
                e.s = src;
                exp_q.push_back(e);
            end
            exp_fwd++;
        end
    endtask

    // Per-cycle compare against the model.
    int         hs_cnt = 0;
    int         cyc = 0;
    int         first_hs = -1;
    int         last_hs = -1;
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data = 8'd0;
    logic       prev_last = 1'b0;

    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (brx_empty) check("rd_en_while_empty", brx_rd_en, 1'b0);
            if (prev_stall) begin
                check("stall_valid_hold", m_valid, 1'b1);
                check("stall_data_hold", m_data, prev_data);
                check("stall_last_hold", m_last, prev_last);
            end
            if (m_valid && !m_ready) check("stall_no_pop", brx_rd_en, 1'b0);
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_byte", m_data, 64'hDEAD);
                end else begin
                    e = exp_q.pop_front();
                    check("m_data", m_data, e.d);
                    check("m_last", m_last, e.l);
                    check("m_src_addr", m_src_addr, e.s);
                end
                hs_cnt++;
                if (first_hs < 0) first_hs = cyc;
                last_hs = cyc;
            end
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
            prev_last  = m_last;
        end
    end

    task automatic send_hdr(input logic [47:0] dst, input logic [47:0] src, input logic [15:0] len);
        @(posedge clk); #2;
        rx_header.dst_addr = dst;
        rx_header.src_addr = src;
        rx_header.length   = len;
        hdr_valid          = 1'b1;
        @(posedge clk); #2;
        hdr_valid          = 1'b0;
    endtask

    task automatic send_frame(input logic [47:0] dst, input logic [47:0] src,
                              input int len, input logic [7:0] base);
        push_bytes(base, len);
        model_frame(dst, src, len, base);
        send_hdr(dst, src, 16'(len));
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (busy) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s: timeout busy=%0b expected 0", name, busy);
        end
        @(negedge clk); #1;
        check({name, "_all_consumed"}, exp_q.size(), 0);
        check({name, "_fwd_model"}, frames_fwd, exp_fwd);
        check({name, "_drop_model"}, frames_drop, exp_drop);
    endtask

    initial begin
        int pc;
        int hs0;
        int n;

        #3;
        check("rst_rd_en", brx_rd_en, 0);
        check("rst_m_valid", m_valid, 0);
        check("rst_m_last", m_last, 0);
        check("rst_busy", busy, 0);
        check("rst_overrun", hdr_overrun, 0);
        check("rst_m_data", m_data, 0);
        check("rst_src", m_src_addr, 0);
        check("rst_fwd", frames_fwd, 0);
        check("rst_drop", frames_drop, 0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;

        // Forward, with literal latency and throughput pins.
        hs0 = hs_cnt;
        send_frame(MAC, 48'h1122_3344_5566, 10, 8'hA0);
        @(negedge clk);
        check("c1_busy", busy, 1);
        check("c1_rd_en", brx_rd_en, 0);
        check("c1_valid", m_valid, 0);
        @(negedge clk);
        check("c2_rd_en", brx_rd_en, 1);
        check("c2_valid", m_valid, 0);
        @(negedge clk);
        check("c3_valid", m_valid, 1);
        check("c3_data", m_data, 8'hA0);
        check("c3_src", m_src_addr, 48'h1122_3344_5566);
        wait_idle("fwd");
        check("fwd_count_lit", frames_fwd, 1);
        check("fwd_bytes", hs_cnt - hs0, 10);
        check("fwd_span", last_hs - first_hs, 9);

        // Drop on address mismatch.
        pc = pop_cnt;
        send_frame(48'h1234_5678_9ABC, 48'h0A0B_0C0D_0E0F, 5, 8'hB0);
        wait_idle("drop");
        check("drop_pops", pop_cnt - pc, 5);
        check("drop_count_lit", frames_drop, 1);
        check("drop_empty", brx_empty, 1);

        // Broadcast, then promiscuous.
        send_frame(48'hFFFF_FFFF_FFFF, 48'h0000_0000_0001, 1, 8'h55);
        wait_idle("bcast");
        cfg_promisc = 1'b1;
        send_frame(48'h0102_0304_0506, 48'h0000_0000_0002, 1, 8'h66);
        wait_idle("promisc");
        cfg_promisc = 1'b0;
        check("bp_count_lit", frames_fwd, 3);

        // Back-pressure with ready pattern 1,0,0,1.
        hs0 = hs_cnt;
        bp_mode = 1'b1;
        send_frame(MAC, 48'h0000_0000_0003, 4, 8'hC0);
        wait_idle("backpressure");
        bp_mode = 1'b0;
        check("bp_bytes", hs_cnt - hs0, 4);

        // Zero length.
        pc = pop_cnt;
        send_frame(MAC, 48'h0000_0000_0004, 0, 8'h00);
        wait_idle("zero_len");
        check("zero_pops", pop_cnt - pc, 0);
        check("zero_drop_lit", frames_drop, 2);

        // Header arriving mid-forward is ignored and flagged.
        hs0 = hs_cnt;
        send_frame(MAC, 48'h0000_0000_0005, 6, 8'hD0);
        repeat (2) @(posedge clk);
        #2;
        rx_header.dst_addr = MAC;
        rx_header.src_addr = 48'h0000_0000_00EE;
        rx_header.length   = 16'd2;
        hdr_valid          = 1'b1;
        @(posedge clk); #2;
        hdr_valid          = 1'b0;
        @(negedge clk);
        check("overrun_set", hdr_overrun, 1);
        wait_idle("overrun");
        check("overrun_bytes", hs_cnt - hs0, 6);
        check("overrun_fwd_lit", frames_fwd, 5);
        check("overrun_sticky", hdr_overrun, 1);

        // Asynchronous reset after 3 of 10 bytes.
        hs0 = hs_cnt;
        send_frame(MAC, 48'h0000_0000_0006, 10, 8'hE0);
        n = 0;
        while ((hs_cnt - hs0) < 3 && n < 100) begin
            @(negedge clk); #1;
            n++;
        end
        check("mid_reset_reached", hs_cnt - hs0, 3);
        rst_n = 1'b0;
        #1;
        check("ar_rd_en", brx_rd_en, 0);
        check("ar_m_valid", m_valid, 0);
        check("ar_m_last", m_last, 0);
        check("ar_busy", busy, 0);
        check("ar_overrun", hdr_overrun, 0);
        check("ar_m_data", m_data, 0);
        check("ar_src", m_src_addr, 0);
        check("ar_fwd", frames_fwd, 0);
        check("ar_drop", frames_drop, 0);
        exp_q.delete();
        exp_fwd  = 0;
        exp_drop = 0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("post_reset_busy", busy, 0);
        check("post_reset_empty", brx_empty, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/rx_frame_drain_ctrl.md
# rx_frame_drain_ctrl

Controller that sequences readout of the receiver's byte buffer (brx) one frame at a time. It latches each parsed `header`, applies a destination-address filter, then either forwards exactly `length` payload bytes to a downstream valid/ready byte stream with a last marker, or pops and discards them. It sits between the receiver and the frame consumer, owns `brx_rd_en`, and keeps per-frame statistics.

## Interface
Parameters:
- `CNT_W`, default 16: width of the statistics counters.

Ports:
- `clk`, in, 1: single clock; all logic on its rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `cfg_mac_addr`, in, 48: station address; must be stable while `busy`=1.
- `cfg_promisc`, in, 1: 1 = accept every destination address.
- `hdr_valid`, in, 1: one-cycle strobe from the receiver; `rx_header` is valid in that cycle.
- `rx_header`, in, `header`: parsed frame header, with fields `dst_addr[47:0]`, `src_addr[47:0]` and `length[15:0]`.
- `brx_empty`, in, 1: receiver buffer empty.
- `rx_data`, in, 8: head of the receiver buffer (first-word fall-through), valid whenever `brx_empty`=0.
- `brx_rd_en`, out, 1: pops the buffer head; never asserted while `brx_empty`=1.
- `m_data`, out, 8: forwarded payload byte.
- `m_valid`, out, 1: `m_data` is valid.
- `m_last`, out, 1: final payload byte of the frame.
- `m_ready`, in, 1: downstream accepts the byte.
- `m_src_addr`, out, 48: source address of the frame currently being forwarded.
- `busy`, out, 1: state is not IDLE.
- `hdr_overrun`, out, 1: sticky; set when `hdr_valid` arrives while `busy`=1.
- `frames_fwd`, out, `CNT_W`: count of frames forwarded; saturates.
- `frames_drop`, out, `CNT_W`: count of frames dropped; saturates.

## Operation
- **IDLE**
  - On `hdr_valid`, latch `dst_addr`, `src_addr` and `length` into registers, load `remaining` with `length`, and go to CHECK.
- **CHECK** (exactly 1 cycle)
  - Accept if `cfg_promisc`, or `dst_addr` equals `cfg_mac_addr`, or `dst_addr` is 48'hFFFF_FFFF_FFFF.
  - If `length` is 0: increment `frames_drop` and return to IDLE. No pops occur.
  - Else if accepted: go to FORWARD.
  - Else: increment `frames_drop` and go to DROP.
- **FORWARD**
  - Pop condition: `brx_rd_en` = `!brx_empty && remaining!=0 && (!m_valid || m_ready)`.
  - On a pop:
    - `m_data`←`rx_data`
    - `m_valid`←1
    - `m_last`←(`remaining`==1)
    - `remaining`←`remaining`-1
  - If `m_valid && m_ready` and there is no pop, `m_valid`←0 and `m_last`←0.
  - When `m_valid && m_ready && m_last`: increment `frames_fwd` and go to IDLE.
- **DROP**
  - `brx_rd_en` = `!brx_empty && remaining!=0`; each pop decrements `remaining`.
  - When `remaining`==0, go to IDLE.
  - `m_valid` stays 0 in this state.
- **Header overrun**
  - `hdr_valid` in any state other than IDLE is ignored.
  - It sets `hdr_overrun`, which is cleared only by reset.
- **Counters**
  - Increment by 1 per event.
  - Hold at all-ones on overflow.
- **Arithmetic**
  - `remaining` is 16 bits, unsigned, and never decrements below 0.

## Timing
- **Reset values:**
  - State IDLE.
  - `brx_rd_en`, `m_valid`, `m_last`, `busy` and `hdr_overrun` = 0.
  - `m_data` and `m_src_addr` = 0.
  - Both counters = 0.
- **Latency**, with `hdr_valid` in cycle 0:
  - CHECK in cycle 1.
  - Earliest `brx_rd_en` in cycle 2.
  - Earliest `m_valid` in cycle 3.
- **Throughput:** 1 byte per cycle when `brx_empty`=0 and `m_ready`=1 continuously.
- **Back-pressure:**
  - With `m_valid`=1 and `m_ready`=0, `m_data` and `m_last` hold and no pop occurs.
  - A pop and an accept may occur in the same cycle.
- **Buffer underrun:** when `brx_empty` rises mid-frame, pops stall and the state is held with no timeout.
- **Next header:**
  - `hdr_valid` in the same cycle as the return to IDLE is ignored and counted as overrun.
  - The first header that can be accepted is one arriving one cycle after `busy` falls.
- **Asynchronous reset mid-frame:** the FSM returns to IDLE and the partially read frame is abandoned. The receiver must be reset together with this block.

## Structure
- `header` typedef is shared and already in package `defines`.
- Add to `defines`:
  - the state enum `drain_state_e` {IDLE, CHECK, FORWARD, DROP};
  - `BCAST_ADDR` = 48'hFFFF_FFFF_FFFF.
- Single module, no sub-module.
- The output register is the only buffering stage.

## Test plan
- **Forward:** `cfg_mac_addr`=AABBCCDDEEFF; header dst AABBCCDDEEFF, src 112233445566, length 10; payload A0..A9; `m_ready`=1.
  - Expect 10 bytes A0..A9 on consecutive cycles, `m_last` on A9, `m_src_addr`=112233445566, `frames_fwd`=1.
- **Drop:** header dst 123456789ABC with `cfg_promisc`=0, length 5, payload B0..B4.
  - Expect 5 pops, `m_valid` never asserted, `frames_drop`=1, `brx_empty`=1 at the end.
- **Broadcast and promiscuous accept:** broadcast dst with length 1, payload 55; then a non-matching dst with `cfg_promisc`=1.
  - Expect both frames forwarded, each a single byte with `m_last`=1.
- **Back-pressure:** length 4 frame with `m_ready` toggling 1,0,0,1,…
  - Expect no byte lost or duplicated, `m_data` stable while stalled, and `brx_rd_en`=0 on stalled cycles.
- **Zero length and overrun:**
  - Header with length 0: expect no pops and `frames_drop` incremented.
  - `hdr_valid` during FORWARD: expect `hdr_overrun`=1 and the current frame to complete unaffected.
- **Reset mid-frame:** assert `rst_n`=0 after 3 of 10 bytes.
  - Expect every output at its reset value immediately (asynchronously).
